// File: rtl/psum_pkg.sv
// Shared constants, saturation/requantisation helpers and FSM state for psum_reduce_acc.
// Rounding mode: PSUM_ROUND_EN defined selects round-half-up, otherwise floor (truncation).
package psum_pkg;

    localparam int unsigned DEF_N_IN   = 4;
    localparam int unsigned DEF_LANES  = 16;
    localparam int unsigned DEF_IN_W   = 32;
    localparam int unsigned DEF_ACC_W  = 40;
    localparam int unsigned DEF_OUT_W  = 8;
    localparam int unsigned DEF_PASS_W = 8;
    localparam int unsigned SHIFT_W    = 6;

    // Wide signed working width for the helpers; must exceed ACC_W + 1.
    localparam int unsigned CALC_W = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef struct packed {
        calc_t value;
        logic  clipped;
    } sat_res_t;

    // Clamp a signed value into the range of a signed field of the given width.
    function automatic sat_res_t sat_signed(input calc_t value, input int unsigned width);
        calc_t    hi;
        calc_t    lo;
        sat_res_t res;
        hi          = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
        lo          = ~hi;
        res.value   = value;
        res.clipped = 1'b0;
        if (value > hi) begin
            res.value   = hi;
            res.clipped = 1'b1;
        end else if (value < lo) begin
            res.value   = lo;
            res.clipped = 1'b1;
        end
        return res;
    endfunction

    // Shift (optionally rounded), optional ReLU, then saturate to out_w.
    function automatic sat_res_t requant(input calc_t x, input logic [SHIFT_W-1:0] shift,
                                         input logic relu, input int unsigned acc_w,
                                         input int unsigned out_w);
        calc_t v;
`ifdef PSUM_ROUND_EN
        sat_res_t rnd;
`endif
        v = x;
`ifdef PSUM_ROUND_EN
        // Shifts at or beyond the accumulator width only keep the sign, so no rounding there.
        if (shift != '0 && 32'(shift) < acc_w) begin
            rnd = sat_signed(v + (calc_t'(1) <<< (shift - SHIFT_W'(1))), acc_w);
            v   = rnd.value;
        end
`endif
        v = v >>> shift;
        if (relu && v[CALC_W-1]) begin
            v = '0;
        end
        return sat_signed(v, out_w);
    endfunction

endpackage

// File: rtl/psum_lane.sv
// One output lane: N_IN adder tree, S1 register, saturating accumulator and requantiser.
// Rounding behaviour follows PSUM_ROUND_EN through psum_pkg::requant.
module psum_lane
    import psum_pkg::*;
#(
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv,
    input  logic                   accept,
    input  logic [N_IN*IN_W-1:0]   in_data,
    input  logic                   s1_valid,
    input  logic                   s1_first,
    input  logic                   s1_last,
    input  logic [SHIFT_W-1:0]     shift,
    input  logic                   relu,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_sat
);

    logic signed [ACC_W-1:0] tree_sum_c;
    logic signed [ACC_W-1:0] acc_base_c;
    logic signed [ACC_W-1:0] s1_sum;
    logic signed [ACC_W-1:0] acc;
    logic                    sticky;
    sat_res_t                add_res_c;
    sat_res_t                rq_res_c;

    // ACC_W leaves room for N_IN terms, so the tree itself cannot overflow.
    always_comb begin : adder_tree
        tree_sum_c = '0;
        for (int unsigned g = 0; g < N_IN; g++) begin
            tree_sum_c = tree_sum_c + ACC_W'($signed(in_data[g*IN_W +: IN_W]));
        end
    end

    always_comb begin : accumulate
        acc_base_c = acc;
        if (s1_first) begin
            acc_base_c = '0;
        end
        add_res_c = sat_signed(CALC_W'(acc_base_c) + CALC_W'(s1_sum), ACC_W);
        rq_res_c  = requant(add_res_c.value, shift, relu, ACC_W, OUT_W);
    end

    always_ff @(posedge clk or posedge rst) begin : lane_regs
        if (rst) begin
            s1_sum   <= '0;
            acc      <= '0;
            sticky   <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (adv) begin
            if (accept) begin
                s1_sum <= tree_sum_c;
            end
            if (s1_valid) begin
                if (s1_last) begin
                    out_data <= OUT_W'(rq_res_c.value);
                    out_sat  <= sticky | add_res_c.clipped | rq_res_c.clipped;
                    acc      <= '0;
                    sticky   <= 1'b0;
                end else begin
                    acc    <= ACC_W'(add_res_c.value);
                    sticky <= sticky | add_res_c.clipped;
                end
            end
        end
    end

endmodule

// File: rtl/psum_reduce_acc.sv
// Partial-sum reduction stage: per-lane N_IN sum, multi-pass accumulation, requantise to OUT_W.
// Optional round-half-up requantisation is enabled by defining PSUM_ROUND_EN.
module psum_reduce_acc
    import psum_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned IN_W   = DEF_IN_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned PASS_W = DEF_PASS_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PASS_W-1:0]           cfg_passes,
    input  logic [SHIFT_W-1:0]          cfg_shift,
    input  logic                        cfg_relu,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN*LANES*IN_W-1:0]  in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*OUT_W-1:0]      out_data,
    output logic [LANES-1:0]            out_sat,
    output logic                        busy
);

    state_t               state;
    state_t               state_nxt;
    logic [PASS_W-1:0]    beat_cnt;
    logic [PASS_W-1:0]    beat_cnt_nxt;
    logic [PASS_W-1:0]    passes_q;
    logic [PASS_W-1:0]    passes_nxt;
    logic [SHIFT_W-1:0]   shift_q;
    logic [SHIFT_W-1:0]   shift_nxt;
    logic                 relu_q;
    logic                 relu_nxt;
    logic                 adv_c;
    logic                 accept_c;
    logic                 first_c;
    logic                 last_c;
    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_last;

    // Whole pipeline moves only when the output register is free or being drained.
    assign adv_c    = !out_valid || out_ready;
    assign in_ready = adv_c;
    assign accept_c = in_valid && adv_c;
    assign busy     = (state == ACCUM) || s1_valid;

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : fsm_next
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        passes_nxt   = passes_q;
        shift_nxt    = shift_q;
        relu_nxt     = relu_q;
        first_c      = 1'b0;
        last_c       = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    first_c      = 1'b1;
                    passes_nxt   = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
                    shift_nxt    = cfg_shift;
                    relu_nxt     = cfg_relu;
                    beat_cnt_nxt = PASS_W'(1);
                    if (cfg_passes <= PASS_W'(1)) begin
                        last_c = 1'b1;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept_c) begin
                    beat_cnt_nxt = beat_cnt + PASS_W'(1);
                    if (beat_cnt_nxt == passes_q) begin
                        last_c    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Group configuration is held from the first beat so mid-group changes are ignored.
    always_ff @(posedge clk or posedge rst) begin : cfg_regs
        if (rst) begin
            beat_cnt <= '0;
            passes_q <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
        end else begin
            beat_cnt <= beat_cnt_nxt;
            passes_q <= passes_nxt;
            shift_q  <= shift_nxt;
            relu_q   <= relu_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : pipe_ctrl
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv_c) begin
            s1_valid  <= accept_c;
            s1_first  <= first_c;
            s1_last   <= last_c;
            out_valid <= s1_valid && s1_last;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [N_IN*IN_W-1:0] lane_in;

        for (genvar g = 0; g < N_IN; g++) begin : g_grp
            assign lane_in[g*IN_W +: IN_W] = in_data[(g*LANES+l)*IN_W +: IN_W];
        end

        psum_lane #(
            .N_IN  (N_IN),
            .IN_W  (IN_W),
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv_c),
            .accept   (accept_c),
            .in_data  (lane_in),
            .s1_valid (s1_valid),
            .s1_first (s1_first),
            .s1_last  (s1_last),
            .shift    (shift_q),
            .relu     (relu_q),
            .out_data (out_data[l*OUT_W +: OUT_W]),
            .out_sat  (out_sat[l])
        );
    end

endmodule

// File: tb/tb_psum_reduce_acc.sv
// Self-checking bench for psum_reduce_acc: vector table, scoreboard and multi-cycle sequences.
module tb_psum_reduce_acc;

    localparam int N_IN   = 4;
    localparam int LANES  = 16;
    localparam int IN_W   = 32;
    localparam int ACC_W  = 40;
    localparam int OUT_W  = 8;
    localparam int IN_TOT = N_IN * LANES * IN_W;
    localparam int OUT_TOT = LANES * OUT_W;

    typedef struct packed {
        logic [OUT_TOT-1:0] data;
        logic [LANES-1:0]   sat;
    } exp_t;

    typedef struct {
        int passes;
        int shift;
        bit relu;
        int v[4];
        int exp_trunc;
        int exp_rnd;
        bit exp_sat;
    } vec_t;

    logic               clk;
    logic               rst;
    logic [7:0]         cfg_passes;
    logic [5:0]         cfg_shift;
    logic               cfg_relu;
    logic               in_valid;
    logic               in_ready;
    logic [IN_TOT-1:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_TOT-1:0] out_data;
    logic [LANES-1:0]   out_sat;
    logic               busy;

    int     checks;
    int     failures;
    exp_t   sb_q[$];
    longint macc[LANES];
    bit     mstk[LANES];
    vec_t   vecs[15];

    psum_reduce_acc dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_passes (cfg_passes),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [OUT_TOT-1:0] act, input logic [OUT_TOT-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IN_TOT-1:0] pack(input int v0, input int v1, input int v2,
                                                input int v3, input int step);
        logic [IN_TOT-1:0] d;
        int va[4];
        va = '{v0, v1, v2, v3};
        d  = '0;
        for (int g = 0; g < N_IN; g++)
            for (int l = 0; l < LANES; l++)
                d[(g*LANES+l)*IN_W +: IN_W] = 32'(va[g] + l * step);
        return d;
    endfunction

    function automatic longint clamp(input longint v, input int w, output bit c);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -hi - 1;
        c  = 1'b0;
        if (v > hi) begin v = hi; c = 1'b1; end
        if (v < lo) begin v = lo; c = 1'b1; end
        return v;
    endfunction

    task automatic model_beat(input logic [IN_TOT-1:0] d, input bit first);
        longint s;
        bit     c;
        for (int l = 0; l < LANES; l++) begin
            s = 0;
            for (int g = 0; g < N_IN; g++)
                s += longint'($signed(d[(g*LANES+l)*IN_W +: IN_W]));
            if (first) begin
                macc[l] = 0;
                mstk[l] = 1'b0;
            end
            macc[l] = clamp(macc[l] + s, ACC_W, c);
            mstk[l] = mstk[l] | c;
        end
    endtask

    function automatic exp_t model_result(input int shift, input bit relu);
        exp_t   e;
        longint x;
        longint y;
        bit     c;
        for (int l = 0; l < LANES; l++) begin
            x = macc[l];
`ifdef PSUM_ROUND_EN
            if (shift > 0 && shift < ACC_W) x = clamp(x + (64'sd1 <<< (shift - 1)), ACC_W, c);
`endif
            if (shift >= ACC_W) y = (x < 0) ? -1 : 0;
            else                y = x >>> shift;
            if (relu && y < 0) y = 0;
            y = clamp(y, OUT_W, c);
            e.data[l*OUT_W +: OUT_W] = 8'(y);
            e.sat[l] = mstk[l] | c;
        end
        return e;
    endfunction

    task automatic drive_beat();
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n > 200) begin
                chk("handshake_timeout", OUT_TOT'(0), OUT_TOT'(1));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Config pins carry junk on non-first beats; the DUT must hold the first-beat config.
    task automatic run_group(input int passes, input int shift, input bit relu,
                             input logic [IN_TOT-1:0] d, input int nbeats,
                             input bit use_tab, input exp_t tab_exp);
        int eff;
        eff = (passes == 0) ? 1 : passes;
        for (int b = 0; b < nbeats; b++) begin
            if (b == 0) begin
                cfg_passes = 8'(passes);
                cfg_shift  = 6'(shift);
                cfg_relu   = relu;
            end else begin
                cfg_passes = 8'($urandom);
                cfg_shift  = 6'($urandom);
                cfg_relu   = ~relu;
            end
            in_data = d;
            model_beat(d, b == 0);
            if (b == eff - 1) sb_q.push_back(use_tab ? tab_exp : model_result(shift, relu));
            drive_beat();
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output act=%h exp=none at %0t", out_data, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_sat", OUT_TOT'(out_sat), OUT_TOT'(e.sat));
                end
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", OUT_TOT'(sb_q.size()), OUT_TOT'(0));
    endtask

    initial begin
        exp_t             te;
        exp_t             none;
        logic [IN_TOT-1:0] d;
        bit               done;
        int               e;

        checks = 0; failures = 0; none = '0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        cfg_passes = '0; cfg_shift = '0; cfg_relu = 1'b0;

        vecs[0]  = '{1, 0,  1'b0, '{10, 20, 30, 40},     100,  100,  1'b0};
        vecs[1]  = '{3, 2,  1'b0, '{1, 2, 3, 4},         7,    8,    1'b0};
        vecs[2]  = '{1, 1,  1'b0, '{-100, -100, -50, -50}, -128, -128, 1'b1};
        vecs[3]  = '{1, 1,  1'b1, '{-100, -100, -50, -50}, 0,    0,    1'b0};
        vecs[4]  = '{0, 0,  1'b0, '{1, 1, 1, -5},        -2,   -2,   1'b0};
        vecs[5]  = '{2, 3,  1'b0, '{5, 5, 5, 0},         3,    4,    1'b0};
        vecs[6]  = '{1, 40, 1'b0, '{7, 0, 0, 0},         0,    0,    1'b0};
        vecs[7]  = '{1, 63, 1'b0, '{-1, 0, 0, 0},        -1,   -1,   1'b0};
        vecs[8]  = '{1, 0,  1'b0, '{1000, 0, 0, 0},      127,  127,  1'b1};
        vecs[9]  = '{1, 4,  1'b1, '{100, 100, 100, 100}, 25,   25,   1'b0};
        vecs[10] = '{1, 1,  1'b0, '{-7, 0, 0, 0},        -4,   -3,   1'b0};
        vecs[11] = '{2, 0,  1'b0, '{-30, -30, 0, 0},     -120, -120, 1'b0};
        vecs[12] = '{1, 0,  1'b0, '{127, 0, 0, 0},       127,  127,  1'b0};
        vecs[13] = '{1, 0,  1'b0, '{-128, 0, 0, 0},      -128, -128, 1'b0};
        vecs[14] = '{1, 0,  1'b0, '{-129, 0, 0, 0},      -128, -128, 1'b1};

        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", OUT_TOT'(out_valid), OUT_TOT'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_sat", OUT_TOT'(out_sat), OUT_TOT'(0));
        chk("rst_in_ready", OUT_TOT'(in_ready), OUT_TOT'(1));
        chk("rst_busy", OUT_TOT'(busy), OUT_TOT'(0));

        // Table vectors, back to back with out_ready held high.
        for (int i = 0; i < 15; i++) begin
`ifdef PSUM_ROUND_EN
            e = vecs[i].exp_rnd;
`else
            e = vecs[i].exp_trunc;
`endif
            for (int l = 0; l < LANES; l++) begin
                te.data[l*OUT_W +: OUT_W] = 8'(e);
                te.sat[l] = vecs[i].exp_sat;
            end
            d = pack(vecs[i].v[0], vecs[i].v[1], vecs[i].v[2], vecs[i].v[3], 0);
            run_group(vecs[i].passes, vecs[i].shift, vecs[i].relu, d,
                      (vecs[i].passes == 0) ? 1 : vecs[i].passes, 1'b1, te);
            if (i == 0) begin
                chk("latency_t1_valid", OUT_TOT'(out_valid), OUT_TOT'(0));
                @(posedge clk);
                #1;
                chk("latency_t2_valid", OUT_TOT'(out_valid), OUT_TOT'(1));
            end
        end
        wait_drain();

        // Output stall for 5 cycles while four single-pass beats are offered.
        fork
            begin
                for (int k = 0; k < 4; k++)
                    run_group(1, 0, 1'b0, pack(k * 3, 1, 2, -k, k + 1), 1, 1'b0, none);
            end
            begin
                @(posedge clk);
                #1 out_ready = 1'b0;
                for (int c = 1; c <= 5; c++) begin
                    @(negedge clk);
                    if (c >= 3) begin
                        chk("stall_in_ready", OUT_TOT'(in_ready), OUT_TOT'(0));
                        chk("stall_out_valid", OUT_TOT'(out_valid), OUT_TOT'(1));
                        if (sb_q.size() > 0) chk("stall_out_data", out_data, sb_q[0].data);
                        else chk("stall_sb_empty", OUT_TOT'(0), OUT_TOT'(1));
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Two lanes at full-scale input over 255 passes: accumulator saturation.
        d = '0;
        for (int g = 0; g < N_IN; g++) begin
            d[(g*LANES+0)*IN_W +: IN_W] = 32'h7FFF_FFFF;
            d[(g*LANES+1)*IN_W +: IN_W] = 32'h7FFF_FFFF;
            d[(g*LANES+2)*IN_W +: IN_W] = 32'hFFFF_FFFF;
        end
        run_group(255, 0, 1'b0, d, 255, 1'b0, none);
        wait_drain();

        // Reset mid-group discards partial accumulation.
        run_group(4, 0, 1'b0, pack(50, 50, 50, 50, 3), 2, 1'b0, none);
        chk("mid_group_busy", OUT_TOT'(busy), OUT_TOT'(1));
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", OUT_TOT'(out_valid), OUT_TOT'(0));
        chk("midrst_out_data", out_data, '0);
        chk("midrst_out_sat", OUT_TOT'(out_sat), OUT_TOT'(0));
        chk("midrst_busy", OUT_TOT'(busy), OUT_TOT'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        chk("postrst_in_ready", OUT_TOT'(in_ready), OUT_TOT'(1));
        run_group(2, 0, 1'b0, pack(1, 2, 3, 4, 1), 2, 1'b0, none);
        wait_drain();

        // Random groups under random output backpressure.
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 16; n++) begin
                    int p;
                    p = int'($urandom_range(3, 0));
                    run_group(p, int'($urandom_range(5, 0)), 1'($urandom_range(1, 0)),
                              pack(int'($urandom_range(200, 0)) - 100, int'($urandom_range(200, 0)) - 100,
                                   int'($urandom_range(200, 0)) - 100, int'($urandom_range(200, 0)) - 100,
                                   int'($urandom_range(8, 0)) - 4),
                              (p == 0) ? 1 : p, 1'b0, none);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(1, 0));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
